// File: rtl/kpad_scan_param_if.sv
// kpad_scan_param_if: keypad pin and key-event bundle between kpad_scan_param and its neighbours.
interface kpad_scan_param_if #(
  parameter int NROWS = 4,
  parameter int NCOLS = 4
);
  logic [NCOLS-1:0] col;
  logic [NROWS-1:0] row;
  logic key_valid;
  logic key_held;
  logic [$clog2(NROWS*NCOLS)-1:0] key_code;
  logic [$clog2(NROWS)-1:0] key_row;
  logic [$clog2(NCOLS)-1:0] key_col;
  modport master (input col, output row, key_valid, key_code, key_row, key_col, key_held);
  modport slave (output col, input row, key_valid, key_code, key_row, key_col, key_held);
endinterface

// File: rtl/kpad_scan_param.sv
// kpad_scan_param: NROWS x NCOLS keypad scanner with settle, debounce, rollover lockout and release debounce.
// Auto-repeat while a key is held is built only when KPAD_REPEAT_EN is defined.
module kpad_scan_param #(
  parameter int NROWS = 4,
  parameter int NCOLS = 4,
  parameter int SETTLE_CYC = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int RELEASE_CYC = 16,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE = 100
) (
  input logic clk,
  input logic reset,
  kpad_scan_param_if.master k
);
  localparam int RW = $clog2(NROWS);
  localparam int CW = $clog2(NCOLS);
  localparam int KW = $clog2(NROWS * NCOLS);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int LW = $clog2(RELEASE_CYC + 1);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, HOLD} state_t;
  state_t state, state_n;
  logic [NCOLS-1:0] col_m, col_s, col_l;
  logic [RW-1:0] ridx, krow;
  logic [CW-1:0] cidx, cidx_n, kcol;
  logic [KW-1:0] kcode;
  logic [SW-1:0] scnt;
  logic [DW-1:0] dcnt;
  logic [LW-1:0] rcnt;
  logic sample, one_hot, match, held_bit, deb_done, rel_done, advance, rep_hit, kvalid, kheld;
  assign sample = state == SCAN && scnt == SW'(SETTLE_CYC - 1);
  assign one_hot = col_s != '0 && (col_s & (col_s - NCOLS'(1))) == '0;
  assign match = col_s == col_l;
  assign held_bit = col_s[cidx];
  assign deb_done = match && dcnt == DW'(DEBOUNCE_CYC - 1);
  assign rel_done = !held_bit && rcnt == LW'(RELEASE_CYC - 1);
  always_comb begin
    cidx_n = '0;
    for (int i = 0; i < NCOLS; i++) if (col_s[i]) cidx_n = CW'(i);
  end
  always_comb begin
    state_n = state;
    advance = 1'b0;
    case (state)
      SCAN: begin
        state_n = sample && one_hot ? DEBOUNCE : SCAN;
        advance = sample && !one_hot;
      end
      DEBOUNCE: begin
        state_n = !match ? SCAN : deb_done ? EMIT : DEBOUNCE;
        advance = !match;
      end
      EMIT: state_n = HOLD;
      default: begin
        state_n = rel_done ? SCAN : HOLD;
        advance = rel_done;
      end
    endcase
  end
`ifdef KPAD_REPEAT_EN
  localparam int PW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
  logic [PW-1:0] rpt;
  logic rep_on;
  // rpt starts at 1 in EMIT so the first repeat lands exactly REPEAT_DELAY cycles after the accept strobe
  assign rep_hit = state == HOLD && held_bit && rpt >= PW'((rep_on ? REPEAT_RATE : REPEAT_DELAY) - 1);
  always_ff @(posedge clk) begin
    if (!reset) begin
      rpt <= '0;
      rep_on <= 1'b0;
    end else begin
      rpt <= state == EMIT ? PW'(1) : state != HOLD || !held_bit || rep_hit ? '0 : rpt + 1'b1;
      rep_on <= state == HOLD && held_bit && (rep_on || rep_hit);
    end
  end
`else
  assign rep_hit = (REPEAT_DELAY | REPEAT_RATE) < 0;
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= SCAN;
      col_m <= '0;
      col_s <= '0;
      col_l <= '0;
      ridx <= '0;
      cidx <= '0;
      scnt <= '0;
      dcnt <= '0;
      rcnt <= '0;
      kvalid <= 1'b0;
      kheld <= 1'b0;
      kcode <= '0;
      krow <= '0;
      kcol <= '0;
    end else begin
      state <= state_n;
      col_m <= k.col;
      col_s <= col_m;
      if (advance) ridx <= ridx == RW'(NROWS - 1) ? '0 : ridx + 1'b1;
      if (sample && one_hot) begin
        col_l <= col_s;
        cidx <= cidx_n;
      end
      scnt <= state == SCAN && !sample ? scnt + 1'b1 : '0;
      dcnt <= state == DEBOUNCE && match ? dcnt + 1'b1 : '0;
      rcnt <= state == HOLD && !held_bit && !rel_done ? rcnt + 1'b1 : '0;
      kvalid <= state_n == EMIT || rep_hit;
      kheld <= state_n == EMIT || state_n == HOLD;
      if (state_n == EMIT) begin
        kcode <= KW'(ridx) * KW'(NCOLS) + KW'(cidx);
        krow <= ridx;
        kcol <= cidx;
      end
    end
  end
  assign k.row = NROWS'(1) << ridx;
  assign k.key_valid = kvalid;
  assign k.key_held = kheld;
  assign k.key_code = kcode;
  assign k.key_row = krow;
  assign k.key_col = kcol;
endmodule

// File: tb/tb_kpad_scan_param.sv
// tb_kpad_scan_param: directed vectors for kpad_scan_param (repeat build when KPAD_REPEAT_EN is defined).
module tb_kpad_scan_param;
`ifdef KPAD_REPEAT_EN
  localparam int RD = 50, RR = 10;
`else
  localparam int RD = 500, RR = 100;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  int vectors = 0, miscompares = 0;
  kpad_scan_param_if #(.NROWS(4), .NCOLS(4)) kif ();
  kpad_scan_param #(
    .NROWS(4), .NCOLS(4), .SETTLE_CYC(2), .DEBOUNCE_CYC(16), .RELEASE_CYC(16),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (.clk(clk), .reset(reset), .k(kif));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // returns on the first cycle of row r
  task automatic wait_row(input logic [3:0] r);
    int n = 0;
    while (kif.row == r && n < 20) begin tick(); n++; end
    while (kif.row != r && n < 20) begin tick(); n++; end
    check("wait_row", kif.row, r);
  endtask
  // col rises on the last cycle of the row before the target so col_s shows it at the target's sample cycle;
  // returns on the cycle where key_valid is due (sample + 17)
  task automatic press(input logic [3:0] prev_row, input logic [3:0] bits);
    int n = 0;
    wait_row(prev_row);
    tick();
    kif.col = bits;
    tick(2);
    repeat (16) begin tick(); n += int'(kif.key_valid); end
    check("early_valid", n, 0);
    tick();
  endtask
  initial begin
    int n, changes;
    logic [3:0] prev;
    int pulses[$];
    kif.col = '0;
    tick(3);
    check("rst_row", kif.row, 4'b0001);
    check("rst_valid", kif.key_valid, 0);
    check("rst_held", kif.key_held, 0);
    check("rst_code", kif.key_code, 0);
    reset = 1'b1;
    n = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      check("scan_row", kif.row, 32'(1 << ((c / 2) % 4)));
      n += int'(kif.key_valid);
    end
    check("idle_valid", n, 0);
    press(4'b0010, 4'b0010);
    check("k9_valid", kif.key_valid, 1);
    check("k9_code", kif.key_code, 9);
    check("k9_row", kif.key_row, 2);
    check("k9_col", kif.key_col, 1);
    check("k9_held", kif.key_held, 1);
    check("k9_rowdrv", kif.row, 4'b0100);
    tick();
    check("k9_pulse_len", kif.key_valid, 0);
    check("k9_held2", kif.key_held, 1);
    n = 0;
    repeat (180) begin tick(); n += int'(kif.key_valid); end
`ifndef KPAD_REPEAT_EN
    check("k9_single", n, 0);
`endif
    kif.col = '0;
    tick(17);
    check("rel_held_hi", kif.key_held, 1);
    tick();
    check("rel_held_lo", kif.key_held, 0);
    check("rel_rowdrv", kif.row, 4'b1000);
    check("rel_code", kif.key_code, 9);
    wait_row(4'b0001);
    n = 0;
    for (int j = 0; j < 49; j++) begin
      kif.col = (j >= 30 || (j / 3) % 2 == 0) ? 4'b0100 : 4'b0000;
      tick();
      n += int'(kif.key_valid);
    end
    check("bounce_quiet", n, 0);
    kif.col = 4'b0100;
    tick();
    check("bounce_valid", kif.key_valid, 1);
    check("bounce_code", kif.key_code, 14);
    check("bounce_row", kif.key_row, 3);
    check("bounce_col", kif.key_col, 2);
    kif.col = '0;
    tick(20);
    check("bounce_rel", kif.key_held, 0);
    kif.col = 4'b1001;
    n = 0;
    changes = 0;
    prev = kif.row;
    repeat (40) begin
      tick();
      n += int'(kif.key_valid);
      changes += int'(kif.row != prev);
      prev = kif.row;
    end
    check("ghost_valid", n, 0);
    check("ghost_scan", changes, 20);
    check("ghost_held", kif.key_held, 0);
    check("code_kept", kif.key_code, 14);
    kif.col = '0;
    tick(4);
    press(4'b0001, 4'b0010);
    check("k5_valid", kif.key_valid, 1);
    check("k5_code", kif.key_code, 5);
    kif.col = 4'b1010;
    n = 0;
    repeat (40) begin tick(); n += int'(kif.key_valid); end
    check("rollover_valid", n, 0);
    check("rollover_held", kif.key_held, 1);
    check("rollover_row", kif.row, 4'b0010);
    reset = 1'b0;
    kif.col = '0;
    tick();
    check("mid_rst_row", kif.row, 4'b0001);
    check("mid_rst_held", kif.key_held, 0);
    check("mid_rst_code", kif.key_code, 0);
    check("mid_rst_valid", kif.key_valid, 0);
    reset = 1'b1;
`ifdef KPAD_REPEAT_EN
    tick(4);
    press(4'b0010, 4'b0010);
    check("rep_accept", kif.key_valid, 1);
    for (int t = 1; t <= 130; t++) begin
      if (t == 96) kif.col = '0;
      tick();
      if (kif.key_valid) pulses.push_back(t);
    end
    check("rep_count", pulses.size(), 5);
    for (int i = 0; i < 5 && i < pulses.size(); i++) check("rep_offset", pulses[i], 50 + 10 * i);
    check("rep_code", kif.key_code, 9);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
